// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR owner and trap sequencer: interrupt entry, MRET and WFI.
// Optional mcycle/minstret counters are built only when CSR_COUNTER_EN is defined.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        pipe_empty_i,
  input  logic [31:0] pc_i,
  input  logic        instret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  typedef enum logic [2:0] {
    S_IDLE, S_WFI, S_DRAIN, S_SAVE, S_JUMP, S_MRET
  } state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
  logic [29:0] mepc_q, mepc_d;
  logic        stall_q, stall_d, flush_q, flush_d, rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic        take_irq;

  assign take_irq = mie_q & meie_q & interrupt_i;

  // Software writes land first so SAVE/MRET hardware updates override them.
  always_comb begin
    state_d = state_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    meie_d  = meie_q;
    mepc_d  = mepc_q;
    if (csr_we_i) begin
      case (csr_waddr_i)
        A_MSTATUS: begin
          mie_d  = csr_wdata_i[3];
          mpie_d = csr_wdata_i[7];
        end
        A_MIE:   meie_d = csr_wdata_i[11];
        A_MEPC:  mepc_d = csr_wdata_i[31:2];
        default: ;
      endcase
    end
    case (state_q)
      S_IDLE: begin
        if (take_irq)    state_d = S_DRAIN;
        else if (mret_i) state_d = S_MRET;
        else if (wfi_i)  state_d = S_WFI;
      end
      S_WFI: begin
        if (interrupt_i && meie_q) state_d = mie_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (pipe_empty_i) state_d = S_SAVE;
      end
      S_SAVE: begin
        mepc_d  = pc_i[31:2];
        mpie_d  = mie_q;
        mie_d   = 1'b0;
        state_d = S_JUMP;
      end
      S_JUMP: state_d = S_IDLE;
      S_MRET: begin
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    stall_d = (state_d != S_IDLE);
    flush_d = (state_d == S_JUMP) || (state_d == S_MRET);
    rv_d    = flush_d;
    rpc_d   = '0;
    if (state_d == S_JUMP)      rpc_d = MTVEC_BASE;
    else if (state_d == S_MRET) rpc_d = {mepc_d, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      meie_q  <= 1'b0;
      mepc_q  <= '0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      meie_q  <= meie_d;
      mepc_q  <= mepc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  assign stall_o          = stall_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // A software write to one half replaces that half's incremented value.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(instret_i);
    if (csr_we_i) begin
      case (csr_waddr_i)
        A_MCYCLE:    mcycle_d[31:0]    = csr_wdata_i;
        A_MCYCLEH:   mcycle_d[63:32]   = csr_wdata_i;
        A_MINSTRET:  minstret_d[31:0]  = csr_wdata_i;
        A_MINSTRETH: minstret_d[63:32] = csr_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic counters_unused;
  assign counters_unused = instret_i;
`endif

  logic bits_unused;
  assign bits_unused = ^{csr_wdata_i[1:0], pc_i[1:0]};

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      A_MSTATUS:   csr_rdata_o = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MIE:       csr_rdata_o = {20'd0, meie_q, 11'd0};
      A_MTVEC:     csr_rdata_o = MTVEC_BASE;
      A_MEPC:      csr_rdata_o = {mepc_q, 2'b00};
      A_MIP:       csr_rdata_o = {20'd0, interrupt_i, 11'd0};
`ifdef CSR_COUNTER_EN
      A_MCYCLE:    csr_rdata_o = mcycle_q[31:0];
      A_MCYCLEH:   csr_rdata_o = mcycle_q[63:32];
      A_MINSTRET:  csr_rdata_o = minstret_q[31:0];
      A_MINSTRETH: csr_rdata_o = minstret_q[63:32];
`endif
      default:     csr_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: expected values are queued when stimulus
// is applied and popped when the corresponding DUT output is observed.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst, interrupt_i, mret_i, wfi_i, pipe_empty_i, instret_i, csr_we_i;
  logic [31:0] pc_i, csr_wdata_i, csr_rdata_o, redirect_pc_o;
  logic [11:0] csr_waddr_i, csr_raddr_i;
  logic        stall_o, flush_o, redirect_valid_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst), .interrupt_i(interrupt_i), .mret_i(mret_i),
    .wfi_i(wfi_i), .pipe_empty_i(pipe_empty_i), .pc_i(pc_i),
    .instret_i(instret_i), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
    .csr_wdata_i(csr_wdata_i), .csr_raddr_i(csr_raddr_i),
    .csr_rdata_o(csr_rdata_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  function automatic logic [31:0] pop();
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    if (exp_q.size() != 0) v = exp_q.pop_front();
    return v;
  endfunction

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d;
    step();
    csr_we_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a);
    csr_raddr_i = a;
    #1;
    chk_eq(tag, csr_rdata_o, pop());
  endtask

  // Bounded wait for the redirect; an expired bound shows up as a latency error.
  task automatic wait_redirect(input string tag, input int lat);
    int n;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (redirect_valid_o) begin
        n = i;
        break;
      end
    end
    chk_eq({tag, "_lat"}, 32'(n), 32'(lat));
    chk_eq({tag, "_pc"}, redirect_pc_o, pop());
    chk_eq({tag, "_flush"}, 32'(flush_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1; interrupt_i = 1'b0; mret_i = 1'b0; wfi_i = 1'b0;
    pipe_empty_i = 1'b1; pc_i = '0; instret_i = 1'b0; csr_we_i = 1'b0;
    csr_waddr_i = '0; csr_wdata_i = '0; csr_raddr_i = '0;
    step(); step();
    rst = 1'b0;
    chk_eq("rst_stall", 32'(stall_o), 32'd0);
    chk_eq("rst_flush", 32'(flush_o), 32'd0);
    chk_eq("rst_rv", 32'(redirect_valid_o), 32'd0);
    chk_eq("rst_rpc", redirect_pc_o, 32'd0);
    push(32'h0000_1800); rd_chk("rst_mstatus", 12'h300);
    push(32'h0); rd_chk("rst_mepc", 12'h341);

    wr(12'h300, 32'hFFFF_FFFF);
    push(32'h0000_1888); rd_chk("mstatus_ones", 12'h300);
    wr(12'h305, 32'h0);
    push(32'h0001_0000); rd_chk("mtvec_ro", 12'h305);
    wr(12'h304, 32'hFFFF_FFFF);
    push(32'h0000_0800); rd_chk("mie_meie", 12'h304);
    push(32'h0); rd_chk("mip_low", 12'h344);
    wr(12'hFFF, 32'h1234_5678);
    push(32'h0); rd_chk("unmapped", 12'hFFF);

    // Interrupt entry with an already-empty pipe.
    pc_i = 32'h0000_0124; pipe_empty_i = 1'b1; interrupt_i = 1'b1;
    push(32'h0001_0000);
    wait_redirect("irq", 3);
    interrupt_i = 1'b0;
    push(32'h0000_0124); rd_chk("irq_mepc", 12'h341);
    push(32'h0000_1880); rd_chk("irq_mstatus", 12'h300);
    step();
    chk_eq("irq_idle_stall", 32'(stall_o), 32'd0);
    chk_eq("irq_idle_rv", 32'(redirect_valid_o), 32'd0);

    // MRET returns to mepc one cycle after the pulse.
    mret_i = 1'b1; push(32'h0000_0124);
    step();
    mret_i = 1'b0;
    chk_eq("mret_rv", 32'(redirect_valid_o), 32'd1);
    chk_eq("mret_pc", redirect_pc_o, pop());
    chk_eq("mret_flush", 32'(flush_o), 32'd1);
    step();
    push(32'h0000_1888); rd_chk("mret_mstatus", 12'h300);

    // WFI with MIE=0 wakes to IDLE without trapping.
    wr(12'h300, 32'h0);
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("wfi_stall", 32'(stall_o), 32'd1);
      step();
    end
    interrupt_i = 1'b1;
    push(32'h0000_0800); rd_chk("mip_high", 12'h344);
    step();
    chk_eq("wfi_wake_stall", 32'(stall_o), 32'd0);
    chk_eq("wfi_wake_rv", 32'(redirect_valid_o), 32'd0);
    push(32'h0000_0124); rd_chk("wfi_mepc", 12'h341);
    interrupt_i = 1'b0;

    // Trap committed in DRAIN even though the interrupt drops.
    wr(12'h300, 32'h8);
    pc_i = 32'h0000_0203; pipe_empty_i = 1'b0; interrupt_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_eq("drain_stall", 32'(stall_o), 32'd1);
      chk_eq("drain_rv", 32'(redirect_valid_o), 32'd0);
      if (i == 1) interrupt_i = 1'b0;
      step();
    end
    pipe_empty_i = 1'b1;
    push(32'h0001_0000);
    wait_redirect("drain", 2);
    push(32'h0000_0200); rd_chk("drain_mepc", 12'h341);
    push(32'h0000_1880); rd_chk("drain_mstatus", 12'h300);
    step();

    // Reset during SAVE: back to IDLE, no redirect, fields reset.
    wr(12'h300, 32'h8);
    pc_i = 32'h0000_0400; interrupt_i = 1'b1;
    step(); step();
    chk_eq("save_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("rstsave_stall", 32'(stall_o), 32'd0);
    chk_eq("rstsave_rv", 32'(redirect_valid_o), 32'd0);
    push(32'h0000_1800); rd_chk("rstsave_mstatus", 12'h300);
    push(32'h0); rd_chk("rstsave_mepc", 12'h341);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("rstsave_no_redirect", 32'(redirect_valid_o), 32'd0);
    end
    interrupt_i = 1'b0;

`ifdef CSR_COUNTER_EN
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF); rd_chk("mcycle_pre", 12'hB00);
    step();
    push(32'h0); rd_chk("mcycle_lo_wrap", 12'hB00);
    push(32'h1); rd_chk("mcycle_hi_carry", 12'hB80);
    instret_i = 1'b1;
    wr(12'hB02, 32'h5);
    push(32'h5); rd_chk("minstret_wr", 12'hB02);
    step();
    instret_i = 1'b0;
    push(32'h6); rd_chk("minstret_inc", 12'hB02);
    step();
    push(32'h6); rd_chk("minstret_hold", 12'hB02);
`else
    instret_i = 1'b1;
    wr(12'hB02, 32'h5);
    step();
    instret_i = 1'b0;
    push(32'h0); rd_chk("nocnt_b00", 12'hB00);
    push(32'h0); rd_chk("nocnt_b80", 12'hB80);
    push(32'h0); rd_chk("nocnt_b02", 12'hB02);
    push(32'h0); rd_chk("nocnt_b82", 12'hB82);
`endif

    chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

- Machine-mode CSR state owner and trap sequencer for the CPU.
- Holds mstatus, mie, mip, mtvec, mepc and the cycle/instret counters; serves architectural CSR reads; commits WB-stage CSR writes.
- Sequences external-interrupt entry, MRET return and WFI sleep by stalling, draining, flushing and redirecting the pipeline.
- Its read port feeds the EX-stage CSR forwarding mux as the register-file (no-forward) source.

## Interface
Parameters:
- MTVEC_BASE, 32'h0001_0000, fixed trap vector; mtvec is read-only.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- interrupt_i  in  1  external interrupt level (MEIP)
- mret_i  in  1  MRET at commit point, one-cycle pulse
- wfi_i  in  1  WFI at commit point, one-cycle pulse
- pipe_empty_i  in  1  all older instructions retired
- pc_i  in  32  PC of the oldest unretired instruction; stable while stall_o=1
- instret_i  in  1  one instruction retired this cycle
- csr_we_i  in  1  WB-stage CSR write enable
- csr_waddr_i  in  12  write address
- csr_wdata_i  in  32  write data, already resolved for CSRRW/S/C
- csr_raddr_i  in  12  read address
- csr_rdata_o  out  32  read data, combinational
- stall_o  out  1  freeze fetch/decode
- flush_o  out  1  kill IF/ID/EX contents
- redirect_valid_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  redirect target

## Operation
Register fields and read values:
- mstatus (300): read {19'd0, 2'b11, 3'd0, MPIE, 3'd0, MIE, 3'd0}; MPP hardwired 11; writes update only bits 7 and 3.
- mie (304): only MEIE (bit 11) is stored.
- mtvec (305): reads MTVEC_BASE; writes ignored.
- mepc (341): stores bits [31:2]; bits [1:0] read 0.
- mip (344): read-only; bit 11 = interrupt_i.
- Counters: mcycle b00/b80 (lo/hi), minstret b02/b82 (lo/hi).
- Unmapped read addresses return 0; unmapped writes are ignored.

Interrupt and FSM rules:
- take_irq = MIE & MEIE & interrupt_i.
- FSM states: IDLE, WFI, DRAIN, SAVE, JUMP, MRET.
- IDLE priority: take_irq -> DRAIN; else mret_i -> MRET; else wfi_i -> WFI; else stay.
- WFI: leave when interrupt_i & MEIE (MIE ignored). If MIE=1 -> DRAIN, else -> IDLE and execution resumes.
- DRAIN: hold until pipe_empty_i=1, then -> SAVE. Once DRAIN is entered the trap is committed, even if interrupt_i drops.
- SAVE: mepc <= pc_i; MPIE <= MIE; MIE <= 0; then -> JUMP.
- JUMP: flush_o=1, redirect_valid_o=1, redirect_pc_o=MTVEC_BASE; then -> IDLE.
- MRET: MIE <= MPIE; MPIE <= 1; flush_o=1, redirect_valid_o=1, redirect_pc_o={mepc[31:2],2'b00}; then -> IDLE.

Outputs and write conflicts:
- stall_o = (state != IDLE).
- redirect_pc_o = 0 when redirect_valid_o=0.
- csr_we_i is honoured in every state.
- In the same cycle, a hardware update in SAVE/MRET beats a software write to the same field; other fields of that write still commit.

## Timing
- Reset values: all outputs 0, state IDLE, MIE=MPIE=0, MEIE=0, mepc=0, counters=0.
- A write at edge N is visible on csr_rdata_o after edge N. There is no internal bypass; the forwarding mux covers the write-to-read window.
- Interrupt entry: take_irq sampled at edge N leads to DRAIN after N. With pipe_empty_i already 1, SAVE follows after N+1 and JUMP after N+2. Redirect and flush are driven in the JUMP cycle, 3 cycles after sampling at minimum.
- MRET: redirect appears in the cycle after the mret_i edge.
- mcycle: +1 every cycle after reset.
- minstret: +1 per cycle with instret_i=1.
- 64-bit counters carry from lo into hi. A software write to either half in a cycle replaces that half's next value, overriding that cycle's increment.
- rst in any state: IDLE and reset values at the next edge, no redirect issued.

## Configuration
- CSR_COUNTER_EN defined: mcycle and minstret implemented as above.
- CSR_COUNTER_EN undefined: counters removed; b00/b02/b80/b82 read 0; writes and instret_i ignored.

## Test plan
- After reset, write mstatus=0xFFFF_FFFF, then read: 0x0000_1888. mtvec reads 0x0001_0000 after writing 0.
- MIE=1, MEIE=1, pc_i=0x0000_0124, pipe_empty_i=1, raise interrupt_i: redirect to 0x0001_0000 exactly 3 cycles later; mepc=0x124; mstatus=0x1880.
- Then pulse mret_i: next cycle redirect to 0x124 with flush_o=1; mstatus=0x1888.
- MIE=0, MEIE=1, pulse wfi_i: stall_o held. Raise interrupt_i: back to IDLE next cycle, no redirect, mepc unchanged.
- Hold pipe_empty_i=0 for 5 DRAIN cycles and drop interrupt_i mid-drain: trap still taken once pipe_empty_i=1. Assert rst during SAVE: IDLE, no redirect.
- With CSR_COUNTER_EN: preload mcycle lo=0xFFFF_FFFF: next cycle lo=0, hi=1. Write minstret lo=5 while instret_i=1: reads 5. Without CSR_COUNTER_EN: all four counter addresses read 0.
